// File: rtl/rr_arbiter_param.sv
// Parameterised round-robin / fixed-priority arbiter with registered one-hot grant,
// optional tenure limit and a one-cycle timeout pulse on forced release.
module rr_arbiter_param #(
    parameter  int N        = 32,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     rr_mask;
    logic [N-1:0]     rr_req;
    logic [N-1:0]     pick_vec;
    logic [IDX_W-1:0] winner;
    logic             holder_req;
    logic             expire;

    // Requesters at or above the pointer; if none of them ask, the search wraps to index 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign rr_mask[gi] = (IDX_W'(gi) >= ptr_q);
        end
    endgenerate

    assign rr_req = req & rr_mask;

    always_comb begin
        pick_vec = req;
        if (!mode && (|rr_req)) begin
            pick_vec = rr_req;
        end
    end

    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    assign holder_req = |(req & grant_q);
    assign expire     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_BUSY;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
                    idx_d   = winner;
                    ptr_d   = (winner == IDX_W'(N - 1)) ? '0 : winner + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            S_BUSY: begin
                if (ack || !holder_req || expire) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    idx_d     = '0;
                    hold_d    = '0;
                    // Only a pure expiry counts as forced; a coincident ack or drop is a normal release.
                    timeout_d = expire && !ack && holder_req;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == S_BUSY);
    assign grant_idx   = idx_q;
    assign timeout     = timeout_q;

endmodule
